// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares the single main-memory port between the instruction cache (read-only)
// and the data cache (read/write). One transaction is in flight at a time.
// Requests are granted combinationally in IDLE, latched, issued to memory, and
// completed with a one-cycle, address-tagged response pulse to the owning cache.
//
// Build option:
//   MEM_ARB_DCACHE_PRIORITY_EN  - when defined, the dcache wins every conflict,
//                                 except that after 8 consecutive conflict wins
//                                 the waiting icache is granted once. When
//                                 undefined, conflicts are resolved round-robin.
//
// Ports:
//   clock, reset                 - clock, asynchronous active-low reset
//   i_req_valid/addr/ready       - icache read request handshake
//   i_resp_valid/addr/data       - icache response pulse
//   d_req_valid/write/addr/data  - dcache request (read or write)
//   d_req_ready                  - dcache request accepted this cycle
//   d_resp_valid/addr/data       - dcache response pulse (data is 0 for writes)
//   resp_err                     - marks the current response as a timeout
//   mem_read/write/address/data_out - memory command, held until mem_ready
//   mem_ready                    - memory accepts the command
//   mem_valid/addr_in/data_in    - tagged read data from memory

module mem_port_arbiter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDRESS_BITS   = 20,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  // icache
  input  logic                    i_req_valid,
  input  logic [ADDRESS_BITS-1:0] i_req_addr,
  output logic                    i_req_ready,
  output logic                    i_resp_valid,
  output logic [ADDRESS_BITS-1:0] i_resp_addr,
  output logic [DATA_WIDTH-1:0]   i_resp_data,
  // dcache
  input  logic                    d_req_valid,
  input  logic                    d_req_write,
  input  logic [ADDRESS_BITS-1:0] d_req_addr,
  input  logic [DATA_WIDTH-1:0]   d_req_data,
  output logic                    d_req_ready,
  output logic                    d_resp_valid,
  output logic [ADDRESS_BITS-1:0] d_resp_addr,
  output logic [DATA_WIDTH-1:0]   d_resp_data,
  output logic                    resp_err,
  // memory
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDRESS_BITS-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]   mem_data_out,
  input  logic                    mem_ready,
  input  logic                    mem_valid,
  input  logic [ADDRESS_BITS-1:0] mem_addr_in,
  input  logic [DATA_WIDTH-1:0]   mem_data_in
);

  // Last cycle spent in WAIT_RESP before the timeout fires.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitResp, StRespond} state_e;

  state_e                  state_q;
  logic                    owner_d_q;  // 1: transaction belongs to the dcache
  logic                    write_q;
  logic [ADDRESS_BITS-1:0] addr_q;
  logic [7:0]              timer_q;

  logic                    grant_i;
  logic                    grant_d;
  logic                    idle;
  logic                    accept;
  logic                    grant_write;
  logic [ADDRESS_BITS-1:0] grant_addr;
  logic                    addr_match;

  logic                    resp_go;
  logic                    resp_err_d;
  logic [DATA_WIDTH-1:0]   resp_data_d;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef MEM_ARB_DCACHE_PRIORITY_EN
  // Consecutive dcache wins while the icache was also requesting.
  logic [3:0] starve_q;
  logic       icache_due;

  assign icache_due = (starve_q == 4'd8);

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (i_req_valid && d_req_valid) begin
      grant_i = icache_due;
      grant_d = ~icache_due;
    end else begin
      grant_i = i_req_valid;
      grant_d = d_req_valid;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_q <= 4'd0;
    end else if (accept) begin
      if (grant_d && i_req_valid) begin
        starve_q <= starve_q + 4'd1;
      end else begin
        starve_q <= 4'd0;
      end
    end
  end
`else
  // 1: the dcache is favoured at the next conflict.
  logic prio_d_q;

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (i_req_valid && d_req_valid) begin
      grant_i = ~prio_d_q;
      grant_d = prio_d_q;
    end else begin
      grant_i = i_req_valid;
      grant_d = d_req_valid;
    end
  end

  // The requester that just lost (or did not ask) gets priority next time.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prio_d_q <= 1'b0;
    end else if (accept) begin
      prio_d_q <= grant_i;
    end
  end
`endif

  assign idle        = (state_q == StIdle);
  // Gated by reset so every output reads 0 while reset is held.
  assign i_req_ready = reset & idle & grant_i;
  assign d_req_ready = reset & idle & grant_d;
  assign accept      = i_req_ready | d_req_ready;
  // The icache only ever reads, whatever d_req_write says.
  assign grant_write = grant_d & d_req_write;
  assign grant_addr  = grant_d ? d_req_addr : i_req_addr;
  assign addr_match  = mem_valid & (mem_addr_in == addr_q);

  // ---------------------------------------------------------------------------
  // Completion decode: which cycle moves to RESPOND and with what payload
  // ---------------------------------------------------------------------------
  always_comb begin
    resp_go     = 1'b0;
    resp_err_d  = 1'b0;
    resp_data_d = '0;
    case (state_q)
      StIssue: begin
        resp_go = mem_ready & write_q;
      end
      StWaitResp: begin
        if (addr_match) begin
          resp_go     = 1'b1;
          resp_data_d = mem_data_in;
        end else if (timer_q == TimeoutLast) begin
          resp_go    = 1'b1;
          resp_err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Transaction FSM with registered command and response outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      owner_d_q    <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      timer_q      <= 8'd0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_address  <= '0;
      mem_data_out <= '0;
      i_resp_valid <= 1'b0;
      i_resp_addr  <= '0;
      i_resp_data  <= '0;
      d_resp_valid <= 1'b0;
      d_resp_addr  <= '0;
      d_resp_data  <= '0;
      resp_err     <= 1'b0;
    end else begin
      // Response outputs are a single-cycle pulse; cleared unless refreshed.
      i_resp_valid <= 1'b0;
      i_resp_addr  <= '0;
      i_resp_data  <= '0;
      d_resp_valid <= 1'b0;
      d_resp_addr  <= '0;
      d_resp_data  <= '0;
      resp_err     <= 1'b0;

      if (resp_go) begin
        resp_err <= resp_err_d;
        if (owner_d_q) begin
          d_resp_valid <= 1'b1;
          d_resp_addr  <= addr_q;
          d_resp_data  <= resp_data_d;
        end else begin
          i_resp_valid <= 1'b1;
          i_resp_addr  <= addr_q;
          i_resp_data  <= resp_data_d;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (accept) begin
            owner_d_q    <= grant_d;
            write_q      <= grant_write;
            addr_q       <= grant_addr;
            mem_read     <= ~grant_write;
            mem_write    <= grant_write;
            mem_address  <= grant_addr;
            mem_data_out <= grant_write ? d_req_data : '0;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          if (mem_ready) begin
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_address  <= '0;
            mem_data_out <= '0;
            timer_q      <= 8'd0;
            state_q      <= write_q ? StRespond : StWaitResp;
          end
        end
        StWaitResp: begin
          timer_q <= timer_q + 8'd1;
          if (resp_go) begin
            state_q <= StRespond;
          end
        end
        StRespond: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int TO = 255;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_req_valid, i_req_ready, i_resp_valid;
  logic [19:0] i_req_addr, i_resp_addr;
  logic [31:0] i_resp_data;
  logic        d_req_valid, d_req_write, d_req_ready, d_resp_valid;
  logic [19:0] d_req_addr, d_resp_addr;
  logic [31:0] d_req_data, d_resp_data;
  logic        resp_err;
  logic        mem_read, mem_write, mem_ready, mem_valid;
  logic [19:0] mem_address, mem_addr_in;
  logic [31:0] mem_data_out, mem_data_in;

  mem_port_arbiter #(
    .DATA_WIDTH    (32),
    .ADDRESS_BITS  (20),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .i_req_valid (i_req_valid),
    .i_req_addr  (i_req_addr),
    .i_req_ready (i_req_ready),
    .i_resp_valid(i_resp_valid),
    .i_resp_addr (i_resp_addr),
    .i_resp_data (i_resp_data),
    .d_req_valid (d_req_valid),
    .d_req_write (d_req_write),
    .d_req_addr  (d_req_addr),
    .d_req_data  (d_req_data),
    .d_req_ready (d_req_ready),
    .d_resp_valid(d_resp_valid),
    .d_resp_addr (d_resp_addr),
    .d_resp_data (d_resp_data),
    .resp_err    (resp_err),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_data_out(mem_data_out),
    .mem_ready   (mem_ready),
    .mem_valid   (mem_valid),
    .mem_addr_in (mem_addr_in),
    .mem_data_in (mem_data_in)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: arbitration history and memory contents.
  bit last_was_d = 1'b1;  // icache is favoured out of reset
  int streak     = 0;
  logic [31:0] mem_model [logic [19:0]];

  typedef struct {
    bit          use_d;
    bit          wr;
    logic [19:0] addr;
    logic [31:0] data;
    int          rdy;
    int          vdly;
    bit          bad_tag;
    bit          stray;
    bit          timeout;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_lookup(input logic [19:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {12'hABC, a};
  endfunction

  function automatic bit pick_d(input bit iv, input bit dv);
    if (!iv) return 1'b1;
    if (!dv) return 1'b0;
`ifdef MEM_ARB_DCACHE_PRIORITY_EN
    return streak < 8;
`else
    return !last_was_d;
`endif
  endfunction

  task automatic model_grant(input bit g, input bit iv);
    last_was_d = g;
    if (g && iv) streak++;
    else streak = 0;
  endtask

  task automatic model_reset();
    last_was_d = 1'b1;
    streak     = 0;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "/mem_cmd"}, {mem_read, mem_write, mem_address, mem_data_out}, 64'd0);
    chk({name, "/i_resp"}, {i_resp_valid, i_resp_addr, i_resp_data}, 64'd0);
    chk({name, "/d_resp"}, {d_resp_valid, d_resp_addr, d_resp_data}, 64'd0);
    chk({name, "/misc"}, {resp_err, i_req_ready, d_req_ready}, 64'd0);
  endtask

  // Runs one transaction for whichever requester the model says wins.
  // Called just after a rising edge, in an IDLE cycle, with requests driven.
  task automatic do_txn(input string name, input int rdy, input int vdly, input bit bad_tag,
                        input bit stray, input bit timeout);
    bit          g, wr, busy, early, bad_cmd, drop_ok;
    logic [19:0] a;
    logic [31:0] wd, rd;
    int          m;
    g  = pick_d(i_req_valid, d_req_valid);
    wr = g & d_req_write;
    a  = g ? d_req_addr : i_req_addr;
    wd = d_req_data;
    rd = (wr || timeout) ? 32'd0 : mem_lookup(a);
    busy = 0; early = 0; bad_cmd = 0; drop_ok = 1;

    @(negedge clock);
    chk({name, "/i_ready"}, i_req_ready, !g);
    chk({name, "/d_ready"}, d_req_ready, g);
    chk({name, "/idle_no_resp"}, {i_resp_valid, d_resp_valid}, 0);
    model_grant(g, i_req_valid);
    @(posedge clock); #1;
    if (g) d_req_valid = 0;
    else i_req_valid = 0;

    for (int k = 0; k <= rdy; k++) begin
      mem_ready   = (k == rdy);
      mem_valid   = stray && (k == 0);
      mem_addr_in = a;
      mem_data_in = 32'hBAD0_BAD0;
      @(negedge clock);
      if ({mem_read, mem_write, mem_address} !== {!wr, wr, a}) bad_cmd = 1;
      if (wr && mem_data_out !== wd) bad_cmd = 1;
      busy  |= i_req_ready | d_req_ready;
      early |= i_resp_valid | d_resp_valid;
      @(posedge clock); #1;
    end
    mem_ready = 0;
    mem_valid = 0;
    chk({name, "/cmd_stable"}, bad_cmd, 0);

    if (!wr) begin
      m = timeout ? TO : vdly + 1;
      for (int j = 0; j < m; j++) begin
        mem_valid   = 0;
        mem_addr_in = a ^ 20'h4;
        mem_data_in = 32'h0BAD_0BAD;
        if (!timeout && bad_tag && j == vdly - 1) mem_valid = 1;
        if (!timeout && j == vdly) begin
          mem_valid   = 1;
          mem_addr_in = a;
          mem_data_in = rd;
        end
        @(negedge clock);
        if (j == 0 && (mem_read || mem_write)) drop_ok = 0;
        busy  |= i_req_ready | d_req_ready;
        early |= i_resp_valid | d_resp_valid;
        @(posedge clock); #1;
      end
      mem_valid = 0;
    end

    @(negedge clock);
    if (wr && (mem_read || mem_write)) drop_ok = 0;
    busy |= i_req_ready | d_req_ready;
    chk({name, "/cmd_drop"}, drop_ok, 1);
    chk({name, "/no_early_resp"}, early, 0);
    chk({name, "/no_ready_busy"}, busy, 0);
    chk({name, "/valid"}, {i_resp_valid, d_resp_valid}, {!g, g});
    chk({name, "/addr"}, g ? d_resp_addr : i_resp_addr, a);
    chk({name, "/data"}, g ? d_resp_data : i_resp_data, rd);
    chk({name, "/err"}, resp_err, timeout);
    if (wr) mem_model[a] = wd;
    @(posedge clock); #1;
  endtask

  initial begin
    bit any;
    reset = 0;
    i_req_valid = 0; i_req_addr = '0;
    d_req_valid = 0; d_req_write = 0; d_req_addr = '0; d_req_data = '0;
    mem_ready = 0; mem_valid = 0; mem_addr_in = '0; mem_data_in = '0;

    vecs[0] = '{0, 0, 20'h00040, 32'h0,         0, 2, 0, 0, 0, 32'h0000_0013};
    vecs[1] = '{1, 1, 20'h000A0, 32'hDEADBEEF,  3, 0, 0, 0, 0, 32'h0};
    vecs[2] = '{1, 0, 20'h00100, 32'h0,         0, 2, 1, 0, 0, 32'h0000_0055};
    vecs[3] = '{0, 0, 20'h12345, 32'h0,         2, 0, 0, 1, 0, 32'hCAFE_F00D};
    vecs[4] = '{0, 1, 20'h00044, 32'h1111_2222, 1, 1, 0, 0, 0, 32'h0000_0077};
    vecs[5] = '{1, 0, 20'h00300, 32'h0,         0, 0, 0, 0, 1, 32'h0};

    #3;
    chk_zero("reset");
    @(posedge clock); #1;
    reset = 1;

    // Simultaneous requests straight out of reset, then repeated conflicts.
    i_req_valid = 1; i_req_addr = 20'h00300;
    d_req_valid = 1; d_req_write = 0; d_req_addr = 20'h00304;
    #2;
`ifdef MEM_ARB_DCACHE_PRIORITY_EN
    chk("first_conflict_d_ready", d_req_ready, 1);
`else
    chk("first_conflict_i_ready", i_req_ready, 1);
`endif
    for (int c = 0; c < 10; c++) begin
      do_txn($sformatf("conflict%0d", c), 0, 1, 0, 0, 0);
      if (!i_req_valid) begin i_req_valid = 1; i_req_addr = 20'(20'h00400 + c * 4); end
      if (!d_req_valid) begin d_req_valid = 1; d_req_addr = 20'(20'h00500 + c * 4); end
    end
    do_txn("drain0", 0, 0, 0, 0, 0);
    do_txn("drain1", 0, 0, 0, 0, 0);

    // Directed single-requester vectors.
    for (int v = 0; v < 6; v++) begin
      if (!(vecs[v].use_d && vecs[v].wr)) mem_model[vecs[v].addr] = vecs[v].rdata;
      d_req_write = vecs[v].wr;
      if (vecs[v].use_d) begin
        d_req_valid = 1; d_req_addr = vecs[v].addr; d_req_data = vecs[v].data;
      end else begin
        i_req_valid = 1; i_req_addr = vecs[v].addr;
      end
      do_txn($sformatf("vec%0d", v), vecs[v].rdy, vecs[v].vdly, vecs[v].bad_tag,
             vecs[v].stray, vecs[v].timeout);
    end

    // Reset while waiting for read data.
    d_req_valid = 1; d_req_write = 0; d_req_addr = 20'h00200;
    @(posedge clock); #1;
    d_req_valid = 0; mem_ready = 1;
    @(posedge clock); #1;
    mem_ready = 0;
    @(posedge clock); #2;
    reset = 0;
    #1;
    chk_zero("rst_wait");
    @(posedge clock); #1;
    reset = 1;
    model_reset();
    mem_valid = 1; mem_addr_in = 20'h00200; mem_data_in = 32'h77;
    any = 0;
    @(negedge clock); any |= i_resp_valid | d_resp_valid;
    @(posedge clock); #1; mem_valid = 0;
    @(negedge clock); any |= i_resp_valid | d_resp_valid;
    @(negedge clock); any |= i_resp_valid | d_resp_valid;
    chk("rst_no_late_resp", any, 0);
    @(posedge clock); #1;

    // Reset while a command is on the memory port.
    i_req_valid = 1; i_req_addr = 20'h00020;
    @(posedge clock); #1;
    i_req_valid = 0;
    #1;
    chk("issue_cmd_before_rst", mem_read, 1);
    reset = 0;
    #1;
    chk_zero("rst_issue");
    @(posedge clock); #1;
    reset = 1;
    model_reset();
    i_req_valid = 1; i_req_addr = 20'h00040;
    do_txn("post_reset", 0, 2, 0, 0, 0);

    // Randomised traffic against the model.
    for (int it = 0; it < 80; it++) begin
      int vd;
      if (!i_req_valid && $urandom_range(0, 1) == 1) begin
        i_req_valid = 1;
        i_req_addr  = 20'($urandom_range(0, 15) * 4);
      end
      if (!d_req_valid && ($urandom_range(0, 1) == 1 || !i_req_valid)) begin
        d_req_valid = 1;
        d_req_write = 1'($urandom_range(0, 1));
        d_req_addr  = 20'($urandom_range(0, 15) * 4);
        d_req_data  = $urandom;
      end
      vd = $urandom_range(0, 4);
      do_txn($sformatf("rand%0d", it), $urandom_range(0, 3), vd,
             (vd > 0) && ($urandom_range(0, 1) == 1), 1'($urandom_range(0, 1)), 0);
    end
    for (int k = 0; k < 2; k++) begin
      if (i_req_valid || d_req_valid) do_txn("rand_drain", 0, 0, 0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between the instruction cache (read-only) and the data cache (read/write) in the seven-stage pipeline.
- Handles one outstanding transaction at a time. Requester choice is round-robin; transactions are issued with a latched request.
- Delivers a registered, address-tagged response to the owning cache.
- Sits between the cache miss interfaces and the main-memory model.

Parameters:
- DATA_WIDTH, 32, width of data words
- ADDRESS_BITS, 20, width of word addresses
- TIMEOUT_CYCLES, 255, maximum wait for a read response before an error response is returned (8-bit counter range)

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- i_req_valid  input  1  icache read request
- i_req_addr  input  ADDRESS_BITS  icache request address
- i_req_ready  output  1  icache request accepted this cycle
- i_resp_valid  output  1  icache response pulse
- i_resp_addr  output  ADDRESS_BITS  address of the returned word
- i_resp_data  output  DATA_WIDTH  returned word
- d_req_valid  input  1  dcache request
- d_req_write  input  1  1 = write, 0 = read
- d_req_addr  input  ADDRESS_BITS  dcache request address
- d_req_data  input  DATA_WIDTH  dcache write data
- d_req_ready  output  1  dcache request accepted this cycle
- d_resp_valid  output  1  dcache response pulse (read data, or write completion)
- d_resp_addr  output  ADDRESS_BITS  address of the completed transaction
- d_resp_data  output  DATA_WIDTH  read data; 0 for writes
- resp_err  output  1  qualifies the current resp_valid pulse as a timeout
- mem_read  output  1  memory read command
- mem_write  output  1  memory write command
- mem_address  output  ADDRESS_BITS  memory address
- mem_data_out  output  DATA_WIDTH  memory write data
- mem_ready  input  1  memory accepts the command this cycle
- mem_valid  input  1  memory read data valid
- mem_addr_in  input  ADDRESS_BITS  address tag of the read data
- mem_data_in  input  DATA_WIDTH  read data

Behaviour:
- Reset state: every output is 0, FSM = IDLE, round-robin pointer = icache, timeout counter = 0.
- Reset asserted mid-transaction aborts it: no response is issued, and memory commands drop to 0 immediately.
- FSM states: IDLE, ISSUE, WAIT_RESP, RESPOND.
- IDLE, grant:
  - Grant is combinational. x_req_ready = (state == IDLE) & x_req_valid & (x wins).
  - If only one requester is valid, it wins.
  - If both are valid, the requester not granted last wins; the pointer updates on every grant.
  - At most one ready is high per cycle.
- IDLE, accept: on accept, latch owner, write flag, address and data, then go to ISSUE next cycle. The earliest command cycle is grant+1.
- ISSUE:
  - Drive mem_read or mem_write, with mem_address and mem_data_out from the latch.
  - Hold all command signals stable until mem_ready is sampled high.
  - Read with mem_ready: go to WAIT_RESP and clear the counter.
  - Write with mem_ready: go to RESPOND.
  - Commands drop to 0 the cycle after mem_ready.
- WAIT_RESP:
  - The counter increments every cycle.
  - mem_valid with mem_addr_in == latched address: capture mem_data_in, go to RESPOND.
  - mem_valid with a mismatched address: ignore it and keep waiting.
  - Counter reaches TIMEOUT_CYCLES: go to RESPOND with the error set and data forced to 0.
- RESPOND:
  - Pulse the owner's resp_valid for exactly 1 cycle, with the latched address, data and resp_err. Then return to IDLE.
  - New requests are accepted no earlier than the cycle after RESPOND.
- Fixed latencies:
  - Read, memory ready immediately, data k cycles later: response = grant + 3 + k.
  - Write, memory ready immediately: response = grant + 2.
- mem_valid outside WAIT_RESP is ignored.
- d_req_write is ignored for the icache; icache transactions are always reads.
- Inputs from a requester that is not granted are don't-care. Requesters hold their valid until ready.

Optional Feature:
- Macro: MEM_ARB_DCACHE_PRIORITY_EN.
- Defined: the dcache always wins when both requesters are valid. A 4-bit starvation counter counts consecutive dcache wins while the icache waits. At 8 such wins the icache is granted once and the counter clears.
- Undefined: pure round-robin as described in Behaviour; no starvation counter is built.

Test Plan:
- icache read of 0x00040 only; memory ready at once, valid 2 cycles later with data 0x00000013 → i_req_ready at cycle 0, mem_read at cycle 1, i_resp_valid at cycle 5 with addr 0x00040 and data 0x00000013, resp_err = 0.
- icache and dcache both valid in the same cycle after reset → icache granted first, then dcache. Next simultaneous pair → dcache first. With MEM_ARB_DCACHE_PRIORITY_EN: dcache always first, and the icache wins on the 9th consecutive conflict.
- dcache write of 0x0A0 with data 0xDEADBEEF; mem_ready held low 3 cycles → mem_write, mem_address and mem_data_out stable for all 4 cycles. d_resp_valid 1 cycle after mem_ready, with d_resp_data = 0.
- dcache read of 0x100; memory returns mem_valid with tag 0x104, then tag 0x100 with data 0x55 → the first is ignored; d_resp_data = 0x55 at addr 0x100.
- Read with mem_valid never asserted → resp_err = 1 with d_resp_valid after TIMEOUT_CYCLES in WAIT_RESP, data 0, FSM back in IDLE.
- reset driven low while in WAIT_RESP → all outputs 0 asynchronously. A later mem_valid produces no response, and the next request is granted normally.
